pipe_stage_reg: RTL and testbench

//  Generic, parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 22 ++
 rtl/pipe_skid_slot.sv | 83 ++++++++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_pkg : shared types and helpers for the pipeline stage register  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int          TNEW_W_DEFAULT   = 3;

  typedef logic [4:0]                regaddr_t;
  typedef logic [TNEW_W_DEFAULT-1:0] tnew_t;

  // Saturating decrement: a producer already ready (0) stays ready.
  function automatic logic [31:0] tnew_sat_dec(input logic [31:0] t);
    return (t == 32'd0) ? 32'd0 : t - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_slot.sv
// +----------------------------------------------------------------------+
// | pipe_skid_slot : one stored instruction {pc,data,ctrl,wr,rw,tnew,v}  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter int          CTRL_W   = 16,
  parameter int          TNEW_W   = 3,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  regaddr_t          in_wr,
  input  logic              in_regwrite,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output regaddr_t          out_wr,
  output logic              out_regwrite,
  output logic [TNEW_W-1:0] out_tnew
);

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  regaddr_t          r_wr;
  logic              r_regwrite;
  logic [TNEW_W-1:0] r_tnew;

  // Clear keeps the PC so a bubble still reports where it sits in the stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= PC_RESET;
      r_data     <= '0;
      r_ctrl     <= '0;
      r_wr       <= '0;
      r_regwrite <= 1'b0;
      r_tnew     <= '0;
    end else if (clear) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_ctrl     <= '0;
      r_wr       <= '0;
      r_regwrite <= 1'b0;
      r_tnew     <= '0;
    end else if (load) begin
      r_valid    <= 1'b1;
      r_pc       <= in_pc;
      r_data     <= in_data;
      r_ctrl     <= in_ctrl;
      r_wr       <= in_wr;
      r_regwrite <= in_regwrite;
      r_tnew     <= in_tnew;
    end else if (drain) begin
      r_valid    <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_data     = r_data;
  assign out_ctrl     = r_ctrl;
  assign out_wr       = r_wr;
  assign out_regwrite = r_regwrite;
  assign out_tnew     = r_tnew;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +----------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready inter-stage register with Tnew aging.   |
// | Define PIPE_SKID_EN for a 2-entry skid (no out_ready->in_ready path).|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter int          CTRL_W   = 16,
  parameter int          TNEW_W   = 3,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  regaddr_t          in_wr,
  input  logic              in_regwrite,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output regaddr_t          out_wr,
  output logic              out_regwrite,
  output logic [TNEW_W-1:0] out_tnew
);

  logic              w_accept;
  logic              w_new_rw;
  logic [TNEW_W-1:0] w_new_tnew;

  logic              w_main_valid;
  logic              w_main_rw;
  logic              w_main_load;
  logic              w_main_drain;
  logic [31:0]       w_m_pc;
  logic [DATA_W-1:0] w_m_data;
  logic [CTRL_W-1:0] w_m_ctrl;
  regaddr_t          w_m_wr;
  logic              w_m_rw;
  logic [TNEW_W-1:0] w_m_tnew;

  // Writes to $0 are dropped here so hazard logic never forwards them.
  assign w_new_rw   = in_regwrite & (in_wr != '0);
  assign w_new_tnew = TNEW_W'(tnew_sat_dec(32'(in_tnew)));
  assign w_accept   = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic              w_take;
  logic              w_skid_valid;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic [31:0]       w_s_pc;
  logic [DATA_W-1:0] w_s_data;
  logic [CTRL_W-1:0] w_s_ctrl;
  regaddr_t          w_s_wr;
  logic              w_s_rw;
  logic [TNEW_W-1:0] w_s_tnew;

  assign in_ready     = ~reset & ~stall & ~w_skid_valid;
  assign w_take       = ~stall & w_main_valid & out_ready;
  // Skid entry is always older than the input, so it refills main first.
  assign w_main_load  = ~stall & (~w_main_valid | w_take) & (w_skid_valid | w_accept);
  assign w_main_drain = w_take & ~w_main_load;
  assign w_skid_load  = w_accept & w_main_valid & ~out_ready;
  assign w_skid_drain = w_take & w_skid_valid;

  assign w_m_pc   = w_skid_valid ? w_s_pc   : in_pc;
  assign w_m_data = w_skid_valid ? w_s_data : in_data;
  assign w_m_ctrl = w_skid_valid ? w_s_ctrl : in_ctrl;
  assign w_m_wr   = w_skid_valid ? w_s_wr   : in_wr;
  assign w_m_rw   = w_skid_valid ? w_s_rw   : w_new_rw;
  assign w_m_tnew = w_skid_valid ? w_s_tnew : w_new_tnew;

  pipe_skid_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .TNEW_W(TNEW_W), .PC_RESET(PC_RESET)
  ) u_skid (
    .clk(clk), .reset(reset), .clear(flush), .load(w_skid_load), .drain(w_skid_drain),
    .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_regwrite(w_new_rw), .in_tnew(w_new_tnew),
    .out_valid(w_skid_valid), .out_pc(w_s_pc), .out_data(w_s_data), .out_ctrl(w_s_ctrl),
    .out_wr(w_s_wr), .out_regwrite(w_s_rw), .out_tnew(w_s_tnew)
  );
`else
  assign in_ready     = ~reset & ~stall & (~w_main_valid | out_ready);
  assign w_main_load  = w_accept;
  assign w_main_drain = ~stall & w_main_valid & out_ready & ~w_accept;

  assign w_m_pc   = in_pc;
  assign w_m_data = in_data;
  assign w_m_ctrl = in_ctrl;
  assign w_m_wr   = in_wr;
  assign w_m_rw   = w_new_rw;
  assign w_m_tnew = w_new_tnew;
`endif

  pipe_skid_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .TNEW_W(TNEW_W), .PC_RESET(PC_RESET)
  ) u_main (
    .clk(clk), .reset(reset), .clear(flush), .load(w_main_load), .drain(w_main_drain),
    .in_pc(w_m_pc), .in_data(w_m_data), .in_ctrl(w_m_ctrl), .in_wr(w_m_wr),
    .in_regwrite(w_m_rw), .in_tnew(w_m_tnew),
    .out_valid(w_main_valid), .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_regwrite(w_main_rw), .out_tnew(out_tnew)
  );

  assign out_valid    = w_main_valid;
  assign out_regwrite = w_main_rw & w_main_valid;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +----------------------------------------------------------------------+
// | tb_pipe_stage_reg : randomized bench with a queue-based ref model.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, out_pc;
  logic [63:0] in_data, out_data;
  logic [15:0] in_ctrl, out_ctrl;
  regaddr_t    in_wr, out_wr;
  logic        in_regwrite, out_regwrite;
  logic [2:0]  in_tnew, out_tnew;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] data;
    logic [15:0] ctrl;
    logic [4:0]  wr;
    logic        rw;
    logic [2:0]  tnew;
  } rec_t;

  rec_t q[$];
  rec_t disp;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_wr(in_wr), .in_regwrite(in_regwrite), .in_tnew(in_tnew),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_wr(out_wr), .out_regwrite(out_regwrite), .out_tnew(out_tnew)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic r, input logic st, input logic fl, input logic iv,
                      input logic ordy, input logic [31:0] pc, input logic [63:0] d,
                      input logic [15:0] c, input logic [4:0] wr, input logic rw,
                      input logic [2:0] tn);
    rec_t nr;
    logic exp_ready;
    logic exp_valid;
    @(negedge clk);
    reset = r; stall = st; flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_data = d; in_ctrl = c; in_wr = wr; in_regwrite = rw; in_tnew = tn;
    #1;
    exp_valid = (q.size() > 0);
    exp_ready = !r && !st && ((CAP == 1) ? (q.size() == 0 || ordy) : (q.size() < 2));
    check("in_ready",     64'(in_ready),     64'(exp_ready));
    check("out_valid",    64'(out_valid),    64'(exp_valid));
    check("out_pc",       64'(out_pc),       64'(disp.pc));
    check("out_data",     out_data,          disp.data);
    check("out_ctrl",     64'(out_ctrl),     64'(disp.ctrl));
    check("out_wr",       64'(out_wr),       64'(disp.wr));
    check("out_tnew",     64'(out_tnew),     64'(disp.tnew));
    check("out_regwrite", 64'(out_regwrite), 64'(exp_valid && disp.rw));
    nr.pc = pc; nr.data = d; nr.ctrl = c; nr.wr = wr;
    nr.rw   = rw && (wr != 5'd0);
    nr.tnew = (tn == 3'd0) ? 3'd0 : tn - 3'd1;
    @(posedge clk);
    if (r) begin
      q.delete();
      disp = '0;
      disp.pc = PC_RESET_DEFAULT;
    end else if (fl) begin
      q.delete();
      disp.data = '0; disp.ctrl = '0; disp.wr = '0; disp.rw = 1'b0; disp.tnew = '0;
    end else if (!st) begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && exp_ready) q.push_back(nr);
      if (q.size() > 0) disp = q[0];
    end
  endtask

  task automatic idle(input logic ordy);
    step(0, 0, 0, 0, ordy, 32'h0, 64'h0, 16'h0, 5'd0, 1'b0, 3'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_data = '0; in_ctrl = '0; in_wr = '0; in_regwrite = 1'b0; in_tnew = '0;
    disp = '0;
    disp.pc = PC_RESET_DEFAULT;
    repeat (2) @(posedge clk);

    // Reset values, then aging and $0 suppression
    idle(0);
    step(0, 0, 0, 1, 0, 32'h3004, 64'h1111, 16'h00a5, 5'd5, 1'b1, 3'd2);
    step(0, 0, 0, 1, 1, 32'h3008, 64'h2222, 16'h005a, 5'd6, 1'b1, 3'd0);
    step(0, 0, 0, 1, 1, 32'h300c, 64'h3333, 16'h0f0f, 5'd0, 1'b1, 3'd7);
    idle(0);

    // Stall three cycles with a flush in the middle one
    step(0, 1, 0, 1, 1, 32'h3010, 64'h4444, 16'h1234, 5'd7, 1'b1, 3'd1);
    step(0, 1, 1, 1, 1, 32'h3010, 64'h4444, 16'h1234, 5'd7, 1'b1, 3'd1);
    step(0, 1, 0, 1, 1, 32'h3010, 64'h4444, 16'h1234, 5'd7, 1'b1, 3'd1);
    idle(0);

    // Hold A with out_ready low while B is offered, then release
    step(0, 0, 0, 1, 0, 32'h3020, 64'haaaa, 16'h00aa, 5'd10, 1'b1, 3'd3);
    step(0, 0, 0, 1, 0, 32'h3024, 64'hbbbb, 16'h00bb, 5'd11, 1'b1, 3'd4);
    step(0, 0, 0, 1, 0, 32'h3024, 64'hbbbb, 16'h00bb, 5'd11, 1'b1, 3'd4);
    step(0, 0, 0, 0, 1, 32'h0, 64'h0, 16'h0, 5'd0, 1'b0, 3'd0);
    idle(1);
    idle(1);
    idle(1);

    // Reset while holding a live, stalled instruction
    step(0, 0, 0, 1, 0, 32'h3030, 64'hcccc, 16'h00cc, 5'd12, 1'b1, 3'd5);
    step(1, 1, 0, 1, 0, 32'h3034, 64'hdddd, 16'h00dd, 5'd13, 1'b1, 3'd5);
    idle(0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(5) == 0), ($urandom_range(29) == 0),
           ($urandom_range(2) != 0), ($urandom_range(2) != 0),
           $urandom, {$urandom, $urandom}, 16'($urandom),
           ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
